hv_bundler: RTL and testbench

Downstream consumer of the per-feature shifted hypervectors produced by the HV shifter stage. It accumulates a frame of HVs (one per accepted beat) into per-dimension saturating counters. At end of frame it thresholds the counters into a single bundled sparse HV. It presents that HV with a valid/ready handshake to the class-similarity stage.

---
 rtl/hdc_pkg.sv | 11 +
 rtl/bundle_counter.sv | 35 +++
 rtl/hv_bundler.sv | 82 ++++++++
 tb/tb_hv_bundler.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/hdc_pkg.sv
// rtl/hdc_pkg.sv - shared HDC constants and bundler state type
package hdc_pkg;
    localparam int HV_DIM        = 16;
    localparam int CNT_W_DEFAULT = 6;

    typedef enum logic [1:0] {
        ACCUM  = 2'd0,
        THRESH = 2'd1,
        OUT    = 2'd2
    } bundler_state_t;
endpackage

// File: rtl/bundle_counter.sv
// rtl/bundle_counter.sv - one saturating per-dimension counter with registered compare
module bundle_counter
    import hdc_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             clr,
    input  logic             inc,
    input  logic             cmp_load,
    input  logic [CNT_W-1:0] threshold,
    output logic             ge
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] cnt;

    // ge is the bundled output bit itself, so a counter clear leaves it untouched
    always_ff @(posedge clk) begin
        if (!nrst) begin
            cnt <= '0;
            ge  <= 1'b0;
        end else begin
            if (clr) begin
                cnt <= '0;
            end else if (inc && (cnt != CNT_MAX)) begin
                cnt <= cnt + CNT_W'(1);
            end
            if (cmp_load) begin
                ge <= (cnt >= threshold);
            end
        end
    end
endmodule

// File: rtl/hv_bundler.sv
// rtl/hv_bundler.sv - accumulates a frame of HVs and thresholds it into one bundled HV
module hv_bundler
    import hdc_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              en,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [HV_DIM-1:0] in_hv,
    input  logic              in_last,
    input  logic [CNT_W-1:0]  threshold,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [HV_DIM-1:0] out_hv,
    output logic [CNT_W-1:0]  out_count
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    bundler_state_t   state;
    logic [CNT_W-1:0] sample_cnt;
    logic [CNT_W-1:0] thr_q;
    logic             accept;
    logic             cnt_clr;
    logic             cmp_load;

    assign in_ready = en && (state == ACCUM);
    assign accept   = in_valid && in_ready;
    assign cnt_clr  = en && (state == OUT) && out_ready;
    assign cmp_load = en && (state == THRESH);

    for (genvar g = 0; g < HV_DIM; g++) begin : g_cnt
        bundle_counter #(.CNT_W(CNT_W)) u_cnt (
            .clk       (clk),
            .nrst      (nrst),
            .clr       (cnt_clr),
            .inc       (accept && in_hv[g]),
            .cmp_load  (cmp_load),
            .threshold (thr_q),
            .ge        (out_hv[g])
        );
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            state      <= ACCUM;
            sample_cnt <= '0;
            thr_q      <= '0;
            out_count  <= '0;
            out_valid  <= 1'b0;
        end else if (en) begin
            case (state)
                ACCUM: begin
                    if (accept) begin
                        if (sample_cnt != CNT_MAX) begin
                            sample_cnt <= sample_cnt + CNT_W'(1);
                        end
                        if (in_last) begin
                            thr_q <= threshold;
                            state <= THRESH;
                        end
                    end
                end
                THRESH: begin
                    out_count <= sample_cnt;
                    out_valid <= 1'b1;
                    state     <= OUT;
                end
                OUT: begin
                    if (out_ready) begin
                        out_valid  <= 1'b0;
                        sample_cnt <= '0;
                        state      <= ACCUM;
                    end
                end
                default: state <= ACCUM;
            endcase
        end
    end
endmodule

// File: tb/tb_hv_bundler.sv
// tb/tb_hv_bundler.sv - self-checking bench for hv_bundler
module tb_hv_bundler;
    import hdc_pkg::*;

    localparam int CW  = 6;
    localparam int SAT = (1 << CW) - 1;

    logic              clk = 1'b0;
    logic              nrst, en, in_valid, in_ready, in_last, out_valid, out_ready;
    logic [HV_DIM-1:0] in_hv, out_hv;
    logic [CW-1:0]     threshold, out_count;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    hv_bundler #(.CNT_W(CW)) dut (
        .clk       (clk),
        .nrst      (nrst),
        .en        (en),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_hv     (in_hv),
        .in_last   (in_last),
        .threshold (threshold),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_hv    (out_hv),
        .out_count (out_count)
    );

    typedef struct {
        int                       n;
        logic [3:0][HV_DIM-1:0]   hv;
        logic [CW-1:0]            thr;
        int                       hold;
        logic [HV_DIM-1:0]        exp_hv;
        logic [CW-1:0]            exp_cnt;
    } vec_t;

    vec_t              vecs[5];
    logic [HV_DIM-1:0] beat_q[$];

    int                mcnt[HV_DIM];
    int                msamp, mthr, mode, mcount;
    logic [HV_DIM-1:0] mhv;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        in_hv     = '0;
        out_ready = 1'b0;
    endtask

    task automatic do_reset;
        nrst = 1'b0;
        tick;
        nrst = 1'b1;
    endtask

    // Streams beat_q as one frame, then checks THRESH, OUT hold and handshake.
    task automatic run_frame(input logic [CW-1:0] thr, input int hold,
                             input logic [HV_DIM-1:0] exp_hv, input logic [CW-1:0] exp_cnt,
                             input string name);
        for (int i = 0; i < beat_q.size(); i++) begin
            in_valid  = 1'b1;
            in_hv     = beat_q[i];
            in_last   = (i == beat_q.size() - 1);
            threshold = in_last ? thr : CW'($urandom);
            #1 check({name, " in_ready accum"}, in_ready, 1);
            tick;
        end
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        check({name, " thresh out_valid"}, out_valid, 0);
        check({name, " thresh in_ready"}, in_ready, 0);
        out_ready = 1'b0;
        tick;
        check({name, " out_valid"}, out_valid, 1);
        check({name, " out_hv"}, out_hv, exp_hv);
        check({name, " out_count"}, out_count, exp_cnt);
        for (int h = 0; h < hold; h++) begin
            tick;
            check({name, " hold valid"}, out_valid, 1);
            check({name, " hold hv"}, out_hv, exp_hv);
            check({name, " hold count"}, out_count, exp_cnt);
            check({name, " hold in_ready"}, in_ready, 0);
        end
        out_ready = 1'b1;
        tick;
        out_ready = 1'b0;
        check({name, " post out_valid"}, out_valid, 0);
        check({name, " post in_ready"}, in_ready, 1);
        check({name, " post hv kept"}, out_hv, exp_hv);
        beat_q.delete();
    endtask

    initial begin
        en        = 1'b1;
        threshold = '0;
        idle_inputs();
        nrst = 1'b0;
        tick;
        tick;
        nrst = 1'b1;
        check("reset out_valid", out_valid, 0);
        check("reset out_hv", out_hv, 0);
        check("reset out_count", out_count, 0);
        check("reset in_ready", in_ready, 1);

        vecs[0] = '{1, {16'h0, 16'h0, 16'h0, 16'h0005}, 6'd1, 0, 16'h0005, 6'd1};
        vecs[1] = '{3, {16'h0, 16'h0004, 16'h0006, 16'h0003}, 6'd2, 5, 16'h0006, 6'd3};
        vecs[2] = '{1, {16'h0, 16'h0, 16'h0, 16'h0000}, 6'd0, 1, 16'hFFFF, 6'd1};
        vecs[3] = '{2, {16'h0, 16'h0, 16'hFFFF, 16'hA5A5}, 6'd2, 2, 16'hA5A5, 6'd2};
        vecs[4] = '{4, {16'hF000, 16'h0F00, 16'h00F0, 16'h000F}, 6'd2, 0, 16'h0000, 6'd4};
        for (int v = 0; v < 5; v++) begin
            for (int j = 0; j < vecs[v].n; j++) beat_q.push_back(vecs[v].hv[j]);
            run_frame(vecs[v].thr, vecs[v].hold, vecs[v].exp_hv, vecs[v].exp_cnt,
                      $sformatf("vec%0d", v));
        end

        // counter and sample-count saturation
        for (int j = 0; j < 70; j++) beat_q.push_back('1);
        run_frame(6'd63, 0, 16'hFFFF, 6'd63, "sat63");
        for (int j = 0; j < 62; j++) beat_q.push_back(16'h00FF);
        beat_q.push_back(16'h0F0F);
        run_frame(6'd63, 0, 16'h000F, 6'd63, "sat_edge");

        // en stall mid-frame with in_valid held high
        in_valid = 1'b1;
        in_hv    = 16'h0003;
        in_last  = 1'b0;
        tick;
        en    = 1'b0;
        in_hv = 16'hFFFF;
        for (int k = 0; k < 3; k++) begin
            #1 check("stall in_ready", in_ready, 0);
            tick;
        end
        en = 1'b1;
        beat_q.push_back(16'h0001);
        run_frame(6'd2, 0, 16'h0001, 6'd2, "stall_resume");

        // en low in OUT ignores out_ready
        in_valid  = 1'b1;
        in_hv     = 16'h00F0;
        in_last   = 1'b1;
        threshold = 6'd1;
        tick;
        idle_inputs();
        tick;
        check("en_out valid", out_valid, 1);
        en        = 1'b0;
        out_ready = 1'b1;
        tick;
        tick;
        check("en_out held valid", out_valid, 1);
        check("en_out held hv", out_hv, 16'h00F0);
        en = 1'b1;
        tick;
        out_ready = 1'b0;
        check("en_out released", out_valid, 0);

        // reset mid-frame
        in_valid = 1'b1;
        in_hv    = 16'hFFFF;
        tick;
        tick;
        idle_inputs();
        do_reset();
        check("rst_mid out_valid", out_valid, 0);
        check("rst_mid out_hv", out_hv, 0);
        check("rst_mid out_count", out_count, 0);
        beat_q.push_back(16'h0001);
        run_frame(6'd1, 0, 16'h0001, 6'd1, "after_rst_mid");

        // reset while in OUT
        in_valid  = 1'b1;
        in_hv     = 16'h0F0F;
        in_last   = 1'b1;
        threshold = 6'd1;
        tick;
        idle_inputs();
        tick;
        check("rst_out pre valid", out_valid, 1);
        do_reset();
        check("rst_out out_valid", out_valid, 0);
        check("rst_out out_hv", out_hv, 0);
        check("rst_out out_count", out_count, 0);
        beat_q.push_back(16'h0002);
        run_frame(6'd1, 0, 16'h0002, 6'd1, "after_rst_out");

        // randomized traffic against a frame-level reference model
        idle_inputs();
        do_reset();
        for (int i = 0; i < HV_DIM; i++) mcnt[i] = 0;
        msamp = 0; mthr = 0; mode = 0; mcount = 0; mhv = '0;
        for (int c = 0; c < 3000; c++) begin
            en        = ($urandom_range(0, 9) < 8);
            in_valid  = ($urandom_range(0, 9) < 6);
            in_hv     = HV_DIM'($urandom);
            in_last   = ($urandom_range(0, 3) == 0);
            threshold = CW'($urandom_range(0, 4));
            out_ready = $urandom_range(0, 1) == 1;
            #1;
            check("rnd in_ready", in_ready, en && (mode == 0));
            check("rnd out_valid", out_valid, mode == 2);
            check("rnd out_hv", out_hv, mhv);
            check("rnd out_count", out_count, mcount);
            if (en) begin
                if (mode == 0) begin
                    if (in_valid) begin
                        for (int i = 0; i < HV_DIM; i++)
                            if (in_hv[i]) mcnt[i] = (mcnt[i] + 1 > SAT) ? SAT : mcnt[i] + 1;
                        msamp = (msamp + 1 > SAT) ? SAT : msamp + 1;
                        if (in_last) begin
                            mthr = threshold;
                            mode = 1;
                        end
                    end
                end else if (mode == 1) begin
                    for (int i = 0; i < HV_DIM; i++) mhv[i] = (mcnt[i] >= mthr);
                    mcount = msamp;
                    mode   = 2;
                end else if (out_ready) begin
                    for (int i = 0; i < HV_DIM; i++) mcnt[i] = 0;
                    msamp = 0;
                    mode  = 0;
                end
            end
            tick;
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
